// File: rtl/data_bus_arb_pkg.sv
// Shared types and constants for the data bus arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, ACTIVE, RESP)
//   BUS_W        : width of the avalon_bus address and data words
//   bus_word_t   : one bus address/data word
//   grant_width(): bits needed to hold a requester index (minimum 1)
package data_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int BUS_W = 16;

    typedef logic [BUS_W-1:0] bus_word_t;

    function automatic int grant_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/data_bus_arbiter_rr_picker.sv
// Combinational round-robin priority picker.
// Searches the request vector starting one above last_grant, wrapping
// around, and returns the first requester found.
//   req        in  NUM_REQ   request vector
//   last_grant in  GRANT_W   index of the most recently served requester
//   any_req    out 1         at least one request bit is set
//   grant      out GRANT_W   chosen requester (0 when any_req is low)
module rr_picker
    import data_bus_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int GRANT_W = grant_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic               any_req,
    output logic [GRANT_W-1:0] grant
);

    int idx;

    // Walk the offsets from farthest to nearest so the nearest requester
    // after last_grant is the one written last.
    always_comb begin
        any_req = |req;
        grant   = '0;
        idx     = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (req[idx]) begin
                grant = GRANT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing the single data-memory/I/O bus between
// NUM_REQ masters (requester 0 is the processor data port). One
// transaction is in flight at a time; a transaction that sees no BusDone
// within TIMEOUT_CYCLES is aborted and answered with ReqErr.
//   Clock, Reset          clock, asynchronous active-high reset
//   ReqRead/ReqWrite      per-master level requests, held until ReqDone
//   ReqAddr/ReqWrData     per-master address / write data, master i in [16*i +: 16]
//   ReqRdData             read data, valid in the ReqDone cycle
//   ReqDone               one-cycle completion pulse to the served master
//   ReqErr                high with ReqDone on a timeout abort
//   BusRead/BusWrite      strobes to avalon_bus
//   BusAddr/BusWrData     address / write data to avalon_bus
//   BusRdData/BusDone     read data / completion from avalon_bus
//   dbg_state             current FSM state
//
// Handshake: a master raises ReqRead or ReqWrite and holds it, with stable
// address and data, until it sees its ReqDone bit; the arbiter then gives
// it one RESP cycle to deassert before arbitrating again. Toward the bus,
// the strobe is held with stable address/data until BusDone is sampled
// high (or the timeout expires); the strobe drops on that same edge.
module data_bus_arbiter
    import data_bus_arb_pkg::*;
#(
    parameter int        NUM_REQ        = 2,
    parameter int        TIMEOUT_CYCLES = 1024,
    parameter bus_word_t ERR_DATA       = 16'hFFFF
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       ReqRead,
    input  logic [NUM_REQ-1:0]       ReqWrite,
    input  logic [NUM_REQ*BUS_W-1:0] ReqAddr,
    input  logic [NUM_REQ*BUS_W-1:0] ReqWrData,
    output logic [BUS_W-1:0]         ReqRdData,
    output logic [NUM_REQ-1:0]       ReqDone,
    output logic                     ReqErr,
    output logic                     BusRead,
    output logic                     BusWrite,
    output logic [BUS_W-1:0]         BusAddr,
    output logic [BUS_W-1:0]         BusWrData,
    input  logic [BUS_W-1:0]         BusRdData,
    input  logic                     BusDone,
    output logic [1:0]               dbg_state
);

    localparam int GRANT_W = grant_width(NUM_REQ);
    localparam int CNT_W   = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t         state;
    logic [GRANT_W-1:0] grant;
    logic [GRANT_W-1:0] last_grant;
    logic               is_read;
    logic [CNT_W-1:0]   count;

    logic [NUM_REQ-1:0] req;
    logic               any_req;
    logic [GRANT_W-1:0] pick;
    logic               pick_read;
    bus_word_t          pick_addr;
    bus_word_t          pick_wdata;
    logic [NUM_REQ-1:0] grant_onehot;

    assign req       = ReqRead | ReqWrite;
    assign dbg_state = state;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant),
        .any_req    (any_req),
        .grant      (pick)
    );

    // Read wins when a master raises both strobes.
    always_comb begin
        pick_read    = ReqRead[pick];
        pick_addr    = ReqAddr[int'(pick)*BUS_W +: BUS_W];
        pick_wdata   = ReqWrData[int'(pick)*BUS_W +: BUS_W];
        grant_onehot = '0;
        grant_onehot[grant] = 1'b1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GRANT_W'(NUM_REQ - 1);
            is_read    <= 1'b0;
            count      <= '0;
            BusRead    <= 1'b0;
            BusWrite   <= 1'b0;
            BusAddr    <= '0;
            BusWrData  <= '0;
            ReqRdData  <= '0;
            ReqDone    <= '0;
            ReqErr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant     <= pick;
                        is_read   <= pick_read;
                        BusRead   <= pick_read;
                        BusWrite  <= ~pick_read;
                        BusAddr   <= pick_addr;
                        BusWrData <= pick_wdata;
                        count     <= '0;
                        state     <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    count <= count + CNT_W'(1);
                    // BusDone is checked first so a completion arriving in
                    // the expiry cycle is still a normal completion.
                    if (BusDone) begin
                        BusRead    <= 1'b0;
                        BusWrite   <= 1'b0;
                        ReqRdData  <= is_read ? BusRdData : '0;
                        ReqDone    <= grant_onehot;
                        ReqErr     <= 1'b0;
                        last_grant <= grant;
                        state      <= RESP;
                    end else if (count == CNT_LAST) begin
                        BusRead    <= 1'b0;
                        BusWrite   <= 1'b0;
                        ReqRdData  <= is_read ? ERR_DATA : '0;
                        ReqDone    <= grant_onehot;
                        ReqErr     <= 1'b1;
                        last_grant <= grant;
                        state      <= RESP;
                    end
                end

                RESP: begin
                    // Requests are not looked at here, giving the served
                    // master one cycle to drop its request.
                    ReqDone <= '0;
                    ReqErr  <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
module tb_data_bus_arbiter;
    import data_bus_arb_pkg::*;

    localparam int N     = 3;
    localparam int T     = 8;
    localparam int NEVER = 100;

    logic               Clock;
    logic               Reset;
    logic [N-1:0]       req_rd;
    logic [N-1:0]       req_wr;
    logic [N*16-1:0]    req_addr;
    logic [N*16-1:0]    req_wd;
    logic [15:0]        ReqRdData;
    logic [N-1:0]       ReqDone;
    logic               ReqErr;
    logic               BusRead;
    logic               BusWrite;
    logic [15:0]        BusAddr;
    logic [15:0]        BusWrData;
    logic [15:0]        BusRdData;
    logic               BusDone;
    logic [1:0]         dbg_state;

    data_bus_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (T),
        .ERR_DATA       (16'hFFFF)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ReqRead   (req_rd),
        .ReqWrite  (req_wr),
        .ReqAddr   (req_addr),
        .ReqWrData (req_wd),
        .ReqRdData (ReqRdData),
        .ReqDone   (ReqDone),
        .ReqErr    (ReqErr),
        .BusRead   (BusRead),
        .BusWrite  (BusWrite),
        .BusAddr   (BusAddr),
        .BusWrData (BusWrData),
        .BusRdData (BusRdData),
        .BusDone   (BusDone),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // ---------------- scoreboard state ----------------
    // bus entry: {rd, wr, addr[15:0], wdata[15:0], strobe_cycles[7:0]}
    logic [41:0]   bus_q[$];
    // response entry: {done[N-1:0], err, rdata[15:0]}
    logic [N+16:0] exp_q[$];
    int            lat_q[$];

    int total = 0;
    int bad   = 0;
    bit mon_en   = 1'b0;
    bit slave_en = 1'b0;

    int m_op[N];   // 0 read, 1 write, 2 read+write
    int m_lat[N];  // strobe cycle index in which the slave raises BusDone
    int lg;        // model of last served master

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one transaction from master i.
    task automatic plan_txn(input int i);
        logic        rd;
        logic        err;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] rdata;
        logic [7:0]  dur;
        logic [N-1:0] done;
        rd    = (m_op[i] != 1);
        addr  = req_addr[i*16 +: 16];
        wd    = req_wd[i*16 +: 16];
        err   = (m_lat[i] >= T);
        dur   = err ? 8'(T) : 8'(m_lat[i] + 1);
        rdata = !rd ? 16'h0000 : (err ? 16'hFFFF : (addr ^ 16'h5A5A));
        done  = '0;
        done[i] = 1'b1;
        bus_q.push_back({rd, ~rd, addr, wd, dur});
        exp_q.push_back({done, err, rdata});
        lat_q.push_back(m_lat[i]);
    endtask

    // All masters in mask request together and hold until served, so they
    // are served in rotating order starting one above the last served.
    task automatic plan_round(input logic [N-1:0] mask);
        int i;
        int nxt;
        nxt = lg;
        for (int k = 1; k <= N; k++) begin
            i = (lg + k) % N;
            if (mask[i]) begin
                plan_txn(i);
                nxt = i;
            end
        end
        lg = nxt;
    endtask

    function automatic int pick_lat();
        int v;
        v = $urandom_range(0, 9);
        if (v < 6) return $urandom_range(0, 3);
        if (v == 6) return T - 1;
        if (v == 7) return NEVER;
        return $urandom_range(4, T - 2);
    endfunction

    // ---------------- bus slave model ----------------
    int s_cnt;
    int s_lat;
    initial begin
        BusDone   = 1'b0;
        BusRdData = 16'h0000;
        s_cnt     = 0;
        s_lat     = 0;
        forever begin
            @(negedge Clock);
            if (!slave_en) begin
                BusDone = 1'b0;
                s_cnt   = 0;
            end else if (BusRead || BusWrite) begin
                if (s_cnt == 0) begin
                    s_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                end
                BusDone   = (s_cnt == s_lat);
                BusRdData = BusDone ? (BusAddr ^ 16'h5A5A) : 16'($urandom);
                s_cnt++;
            end else begin
                // Stray completions while idle must be ignored.
                s_cnt     = 0;
                BusDone   = 1'($urandom_range(0, 1));
                BusRdData = 16'($urandom);
            end
        end
    end

    // ---------------- monitor ----------------
    logic [41:0]   cur_bus;
    logic [N+16:0] cur_rsp;
    bit            in_txn = 1'b0;
    int            cyc_cnt = 0;
    initial begin
        forever begin
            @(negedge Clock);
            if (mon_en) begin
                if ((BusRead || BusWrite) && !in_txn) begin
                    if (bus_q.size() == 0) begin
                        check("unexpected_bus_cycle", 1, 0);
                        cur_bus = '0;
                    end else begin
                        cur_bus = bus_q.pop_front();
                    end
                    in_txn  = 1'b1;
                    cyc_cnt = 0;
                end
                if (BusRead || BusWrite) begin
                    check("bus_read",  32'(BusRead),   32'(cur_bus[41]));
                    check("bus_write", 32'(BusWrite),  32'(cur_bus[40]));
                    check("bus_addr",  32'(BusAddr),   32'(cur_bus[39:24]));
                    check("bus_wdata", 32'(BusWrData), 32'(cur_bus[23:8]));
                    cyc_cnt++;
                end else if (in_txn) begin
                    check("strobe_cycles", 32'(cyc_cnt), 32'(cur_bus[7:0]));
                    in_txn = 1'b0;
                end
                if (ReqDone != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'(ReqDone), 0);
                    end else begin
                        cur_rsp = exp_q.pop_front();
                        check("req_done",  32'(ReqDone),   32'(cur_rsp[N+16:17]));
                        check("req_err",   32'(ReqErr),    32'(cur_rsp[16]));
                        check("req_rdata", 32'(ReqRdData), 32'(cur_rsp[15:0]));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] mask;
    int           cyc;

    initial begin
        Reset    = 1'b1;
        req_rd   = '0;
        req_wr   = '0;
        req_addr = '0;
        req_wd   = '0;
        lg       = N - 1;

        repeat (3) @(negedge Clock);
        check("rst_rdata",  32'(ReqRdData), 0);
        check("rst_done",   32'(ReqDone),   0);
        check("rst_err",    32'(ReqErr),    0);
        check("rst_busrd",  32'(BusRead),   0);
        check("rst_buswr",  32'(BusWrite),  0);
        check("rst_addr",   32'(BusAddr),   0);
        check("rst_wdata",  32'(BusWrData), 0);
        check("rst_state",  32'(dbg_state), 32'(IDLE));
        Reset = 1'b0;

        // Reset in the middle of a pending read (slave never answers).
        @(negedge Clock);
        req_addr[16 +: 16] = 16'h1234;
        req_rd[1] = 1'b1;
        @(negedge Clock);
        check("pre_rst_busread", 32'(BusRead), 1);
        check("pre_rst_addr",    32'(BusAddr), 32'h1234);
        #2 Reset = 1'b1;
        #1;
        check("async_rst_busread", 32'(BusRead),   0);
        check("async_rst_done",    32'(ReqDone),   0);
        check("async_rst_state",   32'(dbg_state), 32'(IDLE));
        req_rd = '0;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        mon_en   = 1'b1;
        slave_en = 1'b1;

        for (int r = 0; r < 40; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                m_op[i]  = $urandom_range(0, 2);
                m_lat[i] = pick_lat();
                req_addr[i*16 +: 16] = 16'($urandom);
                req_wd[i*16 +: 16]   = 16'($urandom);
            end
            if (r == 0) begin
                // after reset, 0 and 1 together: 0 goes first
                mask = 3'b011; m_op[0] = 0; m_op[1] = 0; m_lat[0] = 2; m_lat[1] = 1;
            end else if (r == 1) begin
                // timeout on master 1
                mask = 3'b010; m_op[1] = 0; m_lat[1] = NEVER;
            end else if (r == 2) begin
                // completion in the expiry cycle
                mask = 3'b001; m_op[0] = 0; m_lat[0] = T - 1;
                req_addr[0 +: 16] = 16'h1234 ^ 16'h5A5A;
            end else if (r == 3 || r == 4) begin
                // zero-wait writes, alternating masters
                mask = 3'b011; m_op[0] = 1; m_op[1] = 1; m_lat[0] = 0; m_lat[1] = 0;
                req_addr[0 +: 16] = 16'h0010;
                req_addr[16 +: 16] = 16'h0020;
            end
            plan_round(mask);
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    req_rd[i] = (m_op[i] != 1);
                    req_wr[i] = (m_op[i] != 0);
                end
            end
            cyc = 0;
            while (((req_rd | req_wr) != '0) && cyc < 200) begin
                @(negedge Clock);
                cyc++;
                for (int i = 0; i < N; i++) begin
                    if (ReqDone[i]) begin
                        req_rd[i] = 1'b0;
                        req_wr[i] = 1'b0;
                    end
                end
            end
            check("round_served", 32'(req_rd | req_wr), 0);
            req_rd = '0;
            req_wr = '0;
            repeat ($urandom_range(0, 3)) @(negedge Clock);
        end

        // Read+write on master 0, request dropped while the bus cycle runs.
        m_op[0]  = 2;
        m_lat[0] = 4;
        req_addr[0 +: 16] = 16'h2000;
        req_wd[0 +: 16]   = 16'hC0DE;
        plan_round(3'b001);
        req_rd[0] = 1'b1;
        req_wr[0] = 1'b1;
        cyc = 0;
        while (!BusRead && cyc < 50) begin
            @(negedge Clock);
            cyc++;
        end
        check("drop_mid_strobe_seen", 32'(BusRead), 1);
        req_rd = '0;
        req_wr = '0;

        cyc = 0;
        while ((bus_q.size() != 0 || exp_q.size() != 0) && cyc < 300) begin
            @(negedge Clock);
            cyc++;
        end
        check("drain_bus",  32'(bus_q.size()), 0);
        check("drain_resp", 32'(exp_q.size()), 0);
        repeat (2) @(negedge Clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
